// File: rtl/pep_ks_common_definition_pkg.sv
// pep_ks_common_definition_pkg: key-switch array geometry shared across the key-switch blocks.
package pep_ks_common_definition_pkg;
  localparam int LBY = 32;
  localparam int LBZ = 3;
endpackage

// File: rtl/pep_ks_decomp_pkg.sv
// pep_ks_decomp_pkg: default decomposition constants, digit type and FSM states for pep_ks_blwe_decomp.
package pep_ks_decomp_pkg;
  import pep_ks_common_definition_pkg::*;
  localparam int MOD_W_D = 64;
  localparam int KS_B_W_D = 3;
  localparam int KS_L_D = 5;
  localparam int NPASS = (KS_L_D + LBZ - 1) / LBZ;
  localparam int SH = MOD_W_D - KS_L_D * KS_B_W_D;
  typedef logic signed [KS_B_W_D-1:0] digit_t;
  typedef enum logic {IDLE, EMIT} state_t;
  function automatic int npass(input int ks_l, input int lbz);
    return (ks_l + lbz - 1) / lbz;
  endfunction
endpackage

// File: rtl/pep_ks_decomp_core.sv
// pep_ks_decomp_core: rounds one coefficient to KS_L*KS_B_W bits and splits it LSB-first into balanced signed digits.
module pep_ks_decomp_core #(
  parameter int MOD_W = 64,
  parameter int KS_B_W = 3,
  parameter int KS_L = 5
)(
  input  logic [MOD_W-1:0]       x,
  output logic [KS_L*KS_B_W-1:0] digits
);
  localparam int CW = KS_L * KS_B_W;
  localparam int SH = MOD_W - CW;
  localparam logic [MOD_W-1:0] HALF = MOD_W'(1) << (SH - 1);
  logic [CW-1:0] r;
  logic [KS_B_W:0] d;
  logic c;
  assign r = CW'((x + HALF) >> SH);
  // d never exceeds 2^KS_B_W, so d >= 2^(KS_B_W-1) is just its top two bits
  always_comb begin
    digits = '0;
    d = '0;
    c = 1'b0;
    for (int l = 0; l < KS_L; l++) begin
      d = {1'b0, r[l*KS_B_W +: KS_B_W]} + {{KS_B_W{1'b0}}, c};
      c = d[KS_B_W] | d[KS_B_W-1];
      digits[l*KS_B_W +: KS_B_W] = d[KS_B_W-1:0];
    end
  end
endmodule

// File: rtl/pep_ks_blwe_decomp.sv
// pep_ks_blwe_decomp: decomposes LBY coefficients per beat and streams LBZ levels per cycle to the key-switch MAC.
// PEP_KS_DECOMP_STAT_EN adds the stat_beat_cnt accepted-beat counter.
module pep_ks_blwe_decomp
  import pep_ks_decomp_pkg::*;
#(
  parameter int LBY = pep_ks_common_definition_pkg::LBY,
  parameter int LBZ = pep_ks_common_definition_pkg::LBZ,
  parameter int MOD_W = 64,
  parameter int KS_B_W = 3,
  parameter int KS_L = 5
)(
  input  logic                      clk,
  input  logic                      a_rst,
  input  logic [LBY*MOD_W-1:0]      in_data,
  input  logic                      in_last,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [LBZ*LBY*KS_B_W-1:0] out_digit,
  output logic [LBZ*8-1:0]          out_lvl,
  output logic [LBZ-1:0]            out_lvl_vld,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef PEP_KS_DECOMP_STAT_EN
  ,
  output logic [31:0]               stat_beat_cnt
`endif
);
  localparam int NP = npass(KS_L, LBZ);
  localparam int PW = NP > 1 ? $clog2(NP) : 1;
  localparam int CW = KS_L * KS_B_W;
  localparam int DW = LBY * CW;
  state_t state_q, state_d;
  logic [PW-1:0] p_q, p_d;
  logic [DW-1:0] dig_q, dig_d, core_dig;
  logic last_q, last_d, emit, last_p, hs;
  int lvl;
  for (genvar y = 0; y < LBY; y++) begin : g_core
    pep_ks_decomp_core #(.MOD_W(MOD_W), .KS_B_W(KS_B_W), .KS_L(KS_L)) u_core (
      .x(in_data[y*MOD_W +: MOD_W]),
      .digits(core_dig[y*CW +: CW])
    );
  end
  assign emit = state_q == EMIT;
  assign last_p = p_q == PW'(NP - 1);
  assign in_ready = !emit || (last_p && out_ready);
  assign hs = in_valid && in_ready;
  assign out_valid = emit;
  assign out_last = emit && last_q && last_p;
  // a handshake on the final pass reloads in place, so back-to-back beats see no bubble
  always_comb begin
    state_d = state_q;
    p_d = p_q;
    dig_d = dig_q;
    last_d = last_q;
    if (hs) begin
      state_d = EMIT;
      p_d = '0;
      dig_d = core_dig;
      last_d = in_last;
    end else if (emit && out_ready) begin
      state_d = last_p ? IDLE : EMIT;
      p_d = last_p ? '0 : p_q + PW'(1);
    end
  end
  always_comb begin
    out_digit = '0;
    out_lvl = '0;
    out_lvl_vld = '0;
    lvl = 0;
    for (int z = 0; z < LBZ; z++) begin
      lvl = int'(p_q) * LBZ + z;
      if (lvl < KS_L) begin
        out_lvl[z*8 +: 8] = 8'(lvl);
        out_lvl_vld[z] = emit;
        for (int y = 0; y < LBY; y++)
          out_digit[(z*LBY+y)*KS_B_W +: KS_B_W] = dig_q[(y*KS_L+lvl)*KS_B_W +: KS_B_W];
      end
    end
  end
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_q <= IDLE;
      p_q <= '0;
      dig_q <= '0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q <= p_d;
      dig_q <= dig_d;
      last_q <= last_d;
    end
  end
`ifdef PEP_KS_DECOMP_STAT_EN
  logic [31:0] cnt_q, cnt_d;
  assign cnt_d = cnt_q + 32'(hs);
  assign stat_beat_cnt = cnt_q;
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`endif
endmodule

// File: tb/tb_pep_ks_blwe_decomp.sv
// tb_pep_ks_blwe_decomp: table, corner-case and random checks of pep_ks_blwe_decomp against an arithmetic digit model.
module tb_pep_ks_blwe_decomp;
  localparam int LBY = 32, LBZ = 3, MW = 64, BW = 3, KL = 5, NP = 2;
  localparam int DW = LBZ * LBY * BW, IW = LBY * MW;
  typedef int dm_t [LBY][KL];
  typedef struct {
    logic [MW-1:0] x;
    logic last;
    int d[KL];
  } vec_t;
  logic clk = 0, a_rst = 1, in_last = 0, in_valid = 0, out_ready = 1;
  logic [IW-1:0] in_data = '0;
  logic in_ready, out_last, out_valid;
  logic [DW-1:0] out_digit;
  logic [LBZ*8-1:0] out_lvl;
  logic [LBZ-1:0] out_lvl_vld;
`ifdef PEP_KS_DECOMP_STAT_EN
  logic [31:0] stat_beat_cnt;
`endif
  int checks = 0, errors = 0, sent = 0;
  always #5 clk = ~clk;
  pep_ks_blwe_decomp dut (
    .clk(clk), .a_rst(a_rst), .in_data(in_data), .in_last(in_last), .in_valid(in_valid),
    .in_ready(in_ready), .out_digit(out_digit), .out_lvl(out_lvl), .out_lvl_vld(out_lvl_vld),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
`ifdef PEP_KS_DECOMP_STAT_EN
    , .stat_beat_cnt(stat_beat_cnt)
`endif
  );
  // round to 15 bits, then peel base-8 balanced digits off the integer value
  function automatic int ref_digit(input logic [MW-1:0] x, input int l);
    logic [MW-1:0] s;
    longint v;
    int dg;
    s = x + (64'd1 << 48);
    v = longint'(s >> 49);
    dg = 0;
    for (int i = 0; i <= l; i++) begin
      dg = int'(v % 8);
      if (dg >= 4) dg -= 8;
      v = (v - dg) / 8;
    end
    return dg;
  endfunction
  function automatic dm_t model(input logic [IW-1:0] data);
    dm_t m;
    for (int y = 0; y < LBY; y++)
      for (int l = 0; l < KL; l++) m[y][l] = ref_digit(data[y*MW +: MW], l);
    return m;
  endfunction
  function automatic dm_t table_dm(input int d[KL]);
    dm_t m;
    for (int y = 0; y < LBY; y++)
      for (int l = 0; l < KL; l++) m[y][l] = d[l];
    return m;
  endfunction
  function automatic logic [DW-1:0] exp_vec(input dm_t m, input int p);
    logic [DW-1:0] v;
    int l;
    v = '0;
    for (int z = 0; z < LBZ; z++) begin
      l = p * LBZ + z;
      if (l < KL)
        for (int y = 0; y < LBY; y++) v[(z*LBY+y)*BW +: BW] = BW'(m[y][l]);
    end
    return v;
  endfunction
  function automatic logic [IW-1:0] rep(input logic [MW-1:0] x);
    return {LBY{x}};
  endfunction
  function automatic logic [IW-1:0] rnd_data();
    logic [IW-1:0] d;
    for (int y = 0; y < LBY; y++) d[y*MW +: MW] = {$urandom, $urandom};
    return d;
  endfunction
  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic check_pass(input dm_t m, input logic last, input int p, input string tag);
    logic [LBZ*8-1:0] el;
    logic [LBZ-1:0] ev;
    int l;
    el = '0;
    ev = '0;
    for (int z = 0; z < LBZ; z++) begin
      l = p * LBZ + z;
      if (l < KL) begin
        el[z*8 +: 8] = 8'(l);
        ev[z] = 1'b1;
      end
    end
    chk({tag, ".valid"}, DW'(out_valid), DW'(1));
    chk({tag, ".digit"}, out_digit, exp_vec(m, p));
    chk({tag, ".lvl"}, DW'(out_lvl), DW'(el));
    chk({tag, ".lvl_vld"}, DW'(out_lvl_vld), DW'(ev));
    chk({tag, ".last"}, DW'(out_last), DW'(last && p == NP - 1));
  endtask
  task automatic send(input logic [IW-1:0] data, input logic last, input dm_t m, input int stall, input string tag);
    int n;
    in_data = data;
    in_last = last;
    in_valid = 1;
    out_ready = 1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".hs_wait"}, DW'(in_ready), DW'(1));
    @(negedge clk);
    in_valid = 0;
    sent++;
    for (int p = 0; p < NP; p++) begin
      check_pass(m, last, p, tag);
      if (p == 0 && stall > 0) begin
        out_ready = 0;
        repeat (stall) begin
          @(negedge clk);
          check_pass(m, last, p, {tag, ".hold"});
          chk({tag, ".hold_in_ready"}, DW'(in_ready), DW'(0));
        end
        out_ready = 1;
      end
      @(negedge clk);
    end
    chk({tag, ".idle"}, DW'(out_valid), DW'(0));
  endtask
  initial begin
    vec_t tv[8];
    logic [IW-1:0] bb[4];
    tv[0].x = 64'd0;                   tv[0].last = 1; tv[0].d = '{0, 0, 0, 0, 0};
    tv[1].x = 64'd1 << 48;             tv[1].last = 0; tv[1].d = '{1, 0, 0, 0, 0};
    tv[2].x = 64'd1 << 51;             tv[2].last = 0; tv[2].d = '{-4, 1, 0, 0, 0};
    tv[3].x = 64'd1 << 63;             tv[3].last = 1; tv[3].d = '{0, 0, 0, 0, -4};
    tv[4].x = 64'hFFFF_FFFF_FFFF_FFFF; tv[4].last = 0; tv[4].d = '{0, 0, 0, 0, 0};
    tv[5].x = 64'h0006_FFFF_FFFF_FFFF; tv[5].last = 1; tv[5].d = '{3, 0, 0, 0, 0};
    tv[6].x = 64'h000F_0000_0000_0000; tv[6].last = 0; tv[6].d = '{0, 1, 0, 0, 0};
    tv[7].x = 64'hFFFE_0000_0000_0000; tv[7].last = 0; tv[7].d = '{-1, 0, 0, 0, 0};
    repeat (2) @(negedge clk);
    chk("rst.valid", DW'(out_valid), DW'(0));
    chk("rst.lvl_vld", DW'(out_lvl_vld), DW'(0));
    chk("rst.last", DW'(out_last), DW'(0));
    chk("rst.digit", out_digit, DW'(0));
    a_rst = 0;
    #1;
    chk("rst.in_ready", DW'(in_ready), DW'(1));
`ifdef PEP_KS_DECOMP_STAT_EN
    chk("rst.stat", DW'(stat_beat_cnt), DW'(0));
`endif
    @(negedge clk);
    for (int i = 0; i < 8; i++) send(rep(tv[i].x), tv[i].last, table_dm(tv[i].d), 0, $sformatf("tab%0d", i));
    send(rep(64'd1 << 51), 1, table_dm(tv[2].d), 5, "stall");
    for (int k = 0; k < 4; k++) bb[k] = rnd_data();
    in_data = bb[0];
    in_last = 0;
    in_valid = 1;
    out_ready = 1;
    @(negedge clk);
    sent++;
    for (int c = 0; c < 8; c++) begin
      check_pass(model(bb[c/2]), c / 2 == 3, c % 2, "b2b");
      chk("b2b.in_ready", DW'(in_ready), DW'(c % 2));
      if (c % 2 == 1) begin
        if (c / 2 < 3) begin
          in_data = bb[c/2+1];
          in_last = (c / 2 + 1 == 3);
          sent++;
        end else in_valid = 0;
      end
      @(negedge clk);
    end
    chk("b2b.idle", DW'(out_valid), DW'(0));
`ifdef PEP_KS_DECOMP_STAT_EN
    chk("b2b.stat", DW'(stat_beat_cnt), DW'(sent));
`endif
    for (int k = 0; k < 12; k++) begin
      logic [IW-1:0] d;
      logic lst;
      d = rnd_data();
      lst = 1'($urandom_range(0, 1));
      send(d, lst, model(d), int'($urandom_range(0, 2)), $sformatf("rnd%0d", k));
    end
    in_data = rep(64'd1 << 51);
    in_last = 1;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    check_pass(table_dm(tv[2].d), 1, 0, "mid");
    a_rst = 1;
    #1;
    chk("mid.rst_valid", DW'(out_valid), DW'(0));
    chk("mid.rst_lvl_vld", DW'(out_lvl_vld), DW'(0));
    @(negedge clk);
    @(negedge clk);
    a_rst = 0;
    sent = 0;
    @(negedge clk);
    chk("mid.post_valid", DW'(out_valid), DW'(0));
    chk("mid.post_last", DW'(out_last), DW'(0));
    chk("mid.post_in_ready", DW'(in_ready), DW'(1));
    send(rep(64'd1 << 48), 0, table_dm(tv[1].d), 0, "mid.new");
`ifdef PEP_KS_DECOMP_STAT_EN
    chk("mid.stat", DW'(stat_beat_cnt), DW'(sent));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pep_ks_blwe_decomp.md
# pep_ks_blwe_decomp

- Sits directly upstream of the key-switch multiply-accumulate array, feeding it.
- Accepts BLWE mask coefficients, LBY per beat, each MOD_W bits.
- Rounds each coefficient to KS_L·KS_B_W significant bits and splits it into KS_L balanced signed digits.
- Emits LBZ levels × LBY digits per cycle over NPASS = ceil(KS_L/LBZ) cycles per input beat.

## Interface

Parameters:
- LBY, 32, coefficients per beat (from pep_ks_common_definition_pkg)
- LBZ, 3, levels emitted per cycle (from pep_ks_common_definition_pkg)
- MOD_W, 64, coefficient width
- KS_B_W, 3, decomposition base log (digit width)
- KS_L, 5, number of decomposition levels; KS_L·KS_B_W < MOD_W

Ports:
- clk  in  1  clock
- a_rst  in  1  asynchronous, active-high reset
- in_data  in  LBY·MOD_W  coefficients, coef y at [y·MOD_W +: MOD_W]
- in_last  in  1  last beat of ciphertext
- in_valid  in  1  input valid
- in_ready  out  1  input ready
- out_digit  out  LBZ·LBY·KS_B_W  signed digits, index [(z·LBY+y)·KS_B_W +: KS_B_W]
- out_lvl  out  LBZ·8  absolute level index per z slot
- out_lvl_vld  out  LBZ  slot carries a real level (lvl < KS_L)
- out_last  out  1  final pass of an in_last beat
- out_valid  out  1  output valid
- out_ready  in  1  output ready
- stat_beat_cnt  out  32  accepted input beats; present only with PEP_KS_DECOMP_STAT_EN

## Operation

Per-coefficient arithmetic, all unsigned and mod 2^MOD_W:
- SH = MOD_W − KS_L·KS_B_W.
- r = ((x + 2^(SH−1)) mod 2^MOD_W) >> SH, giving KS_L·KS_B_W bits.
- Digits are formed LSB-first, with carry c0 = 0.
- For level l: d = r[l·KS_B_W +: KS_B_W] + c.
- If d ≥ 2^(KS_B_W−1): digit = d − 2^KS_B_W and carry = 1. Otherwise digit = d and carry = 0.
- Digit range is [−2^(KS_B_W−1), 2^(KS_B_W−1)−1].
- The final carry is discarded (modular wrap).
- Level 0 is the least-significant digit.

Datapath:
- On handshake (in_valid & in_ready), all LBY×KS_L digits are computed combinationally and stored in the digit register together with in_last.
- pass counter p runs 0..NPASS−1.
- Pass p drives slot z with level p·LBZ+z.
- Slots with level ≥ KS_L output digit 0, out_lvl_vld=0 and out_lvl=0.

FSM:
- IDLE: out_valid=0, in_ready=1. Handshake → EMIT with p=0.
- EMIT: out_valid=1. On out_ready:
  - if p < NPASS−1: p increments;
  - if p = NPASS−1 and in_valid: load the new beat and set p=0 (stay in EMIT, no bubble);
  - if p = NPASS−1 and no in_valid: go to IDLE.
- in_ready = IDLE | (EMIT & p=NPASS−1 & out_ready). This is combinational from out_ready.
- out_last = stored last & (p = NPASS−1).

## Timing

- Reset: state IDLE, p=0, digit register 0, out_valid=0, out_last=0, out_lvl_vld=0, stat_beat_cnt=0; in_ready=1 once reset is released.
- Latency: out_valid rises the cycle after the input handshake.
- Throughput: one beat every NPASS cycles (2 for the defaults). Back-to-back beats have no idle cycle.
- While out_valid & !out_ready, all outputs stay stable and p holds.
- Reset mid-beat aborts the beat and discards the remaining passes; no partial output is emitted after release.
- NPASS=1 (KS_L ≤ LBZ): every handshake produces exactly one output cycle; behaves as a 1-deep register stage.

## Configuration

- PEP_KS_DECOMP_STAT_EN defined:
  - stat_beat_cnt port exists.
  - Counts accepted input handshakes, wraps at 2^32, reset to 0.
- Undefined: the port and counter are absent; the datapath is identical.

## Structure

- New package pep_ks_decomp_pkg holds:
  - NPASS and SH localparams;
  - the digit typedef (signed KS_B_W);
  - the FSM state enum.
- It imports LBY/LBZ from pep_ks_common_definition_pkg.
- Sub-module pep_ks_decomp_core: purely combinational rounding plus signed split of one coefficient into KS_L digits. It is instantiated LBY times.
- The top holds the FSM, pass counter, digit register and handshake.

## Test plan

All scenarios use defaults (SH=49, NPASS=2).
- x=0 on all y, in_last=1 → two cycles of all-zero digits. Pass 1: out_lvl_vld=3'b011, out_last=1.
- x=2^48 → level0=+1, others 0. x=2^51 → level0=−4, level1=+1.
- x=2^63 → level4=−4, others 0. x=2^64−1 → all digits 0 (rounding wrap).
- Four back-to-back beats with out_ready=1 → eight consecutive valid cycles; in_ready high every second cycle; stat_beat_cnt=4 with the macro.
- out_ready=0 for 5 cycles during pass 0 → outputs stable and in_ready=0; release gives pass 1 next.
- Assert a_rst during pass 0 of a beat → out_valid=0 immediately; after release, a new beat x=2^48 yields level0=+1 with no stale output.
